// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types for the memory stage
//
// Purpose: word/register types, memory-stage FSM states and the MEM/WB
// payload bundle consumed by writeback.
// Ports: none (package).
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

  // Whole MEM/WB latch in one struct so a bubble or reset is one assignment.
  typedef struct packed {
    logic [2:0] final_mux;
    word_t      dmemload;
    word_t      out_port;
    word_t      next_memaddr;
    word_t      u_type;
    regbits_t   wsel;
    logic       regwen;
    logic       temp_halt;
  } mem_wb_t;

endpackage

// File: rtl/llsc_link_reg.sv
// rtl/llsc_link_reg.sv - load-linked / store-conditional link register
//
// Purpose: holds {link_valid, link_addr}; reports whether an SC to addr
// may proceed and clears the link on snoop or local store hits.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr              address of the op currently in MEM
//   ll_done           an LL completes this cycle (sets the link)
//   wr_done           a store or successful SC completes this cycle
//   snoop_inv         remote invalidation strobe
//   snoop_addr        remote invalidation address
//   sc_ok             SC to addr would succeed this cycle
module llsc_link_reg #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] addr,
  input  logic              ll_done,
  input  logic              wr_done,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              sc_ok
);

  logic              link_valid;
  logic [WORD_W-1:0] link_addr;
  logic              snoop_hit;
  logic              store_hit;

  assign snoop_hit = snoop_inv & (snoop_addr == link_addr);
  assign store_hit = wr_done & (addr == link_addr);
  // A snoop landing in the same cycle as the SC check wins: the SC fails.
  assign sc_ok     = link_valid & (link_addr == addr) & ~snoop_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_done) begin
      link_valid <= 1'b1;
      link_addr  <= addr;
    end else if (snoop_hit || store_hit) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage: dcache requests and MEM/WB latch
//
// Purpose: issues one data-cache request at a time, stalls upstream until
// dhit, and registers the payload that writeback consumes. Halt is sticky.
// Optional feature macro: ATOMIC_LLSC_EN (adds LL/SC with snoop invalidation).
// Ports:
//   CLK, nRST                         clock, asynchronous active-low reset
//   ex_*                              EX/MEM latch contents
//   dhit, dmemload_in                 cache completion and read data
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore                         cache request
//   mem_stall                         freeze upstream stages
//   wb_*                              registered MEM/WB payload
//   ex_ll, ex_sc, snoop_inv,
//   snoop_addr                        (ATOMIC_LLSC_EN only)
module memory_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic              ex_dren,
  input  logic              ex_dwen,
  input  logic [WORD_W-1:0] ex_addr,
  input  logic [WORD_W-1:0] ex_store,
  input  logic [2:0]        ex_final_mux,
  input  logic [WORD_W-1:0] ex_out_port,
  input  logic [WORD_W-1:0] ex_next_memaddr,
  input  logic [WORD_W-1:0] ex_u_type,
  input  logic [REG_W-1:0]  ex_wsel,
  input  logic              ex_regwen,
  input  logic              ex_halt,
`ifdef ATOMIC_LLSC_EN
  input  logic              ex_ll,
  input  logic              ex_sc,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
`endif
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload_in,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [2:0]        wb_final_mux,
  output logic [WORD_W-1:0] wb_dmemload,
  output logic [WORD_W-1:0] wb_out_port,
  output logic [WORD_W-1:0] wb_next_memaddr,
  output logic [WORD_W-1:0] wb_u_type,
  output logic [REG_W-1:0]  wb_wsel,
  output logic              wb_regwen,
  output logic              wb_temp_halt
);

  mem_state_t state;
  mem_wb_t    wb_q;
  mem_wb_t    done_wb;
  logic       not_halted;
  logic       rd_req;
  logic       wr_req;
  logic       mem_op;
  logic       complete;

  assign not_halted = (state != HALTED);

`ifdef ATOMIC_LLSC_EN
  logic sc_ok;
  logic sc_fail;

  // A failing SC never reaches the cache; it retires as a 1-cycle op.
  assign sc_fail = ex_sc & ~sc_ok;
  assign rd_req  = ex_dren | ex_ll;
  assign wr_req  = (ex_dwen | ex_sc) & ~sc_fail;

  llsc_link_reg #(.WORD_W(WORD_W)) u_link (
    .clk        (CLK),
    .rst_n      (nRST),
    .addr       (ex_addr),
    .ll_done    (complete & mem_op & rd_req & ex_ll),
    .wr_done    (complete & mem_op & wr_req & ~rd_req),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .sc_ok      (sc_ok)
  );
`else
  assign rd_req = ex_dren;
  assign wr_req = ex_dwen;
`endif

  assign mem_op    = ex_valid & (rd_req | wr_req) & not_halted;
  // Strobes are gated by nRST so an in-flight request drops the moment reset hits.
  assign dmemREN   = nRST & mem_op & rd_req;
  assign dmemWEN   = nRST & mem_op & wr_req & ~rd_req;
  assign dmemaddr  = ex_addr;
  assign dmemstore = ex_store;
  assign mem_stall = nRST & mem_op & ~dhit;

  // dhit only matters when a request is outstanding; non-memory ops retire anyway.
  assign complete  = ex_valid & not_halted & (~mem_op | dhit);

  always_comb begin
    done_wb              = wb_q;
    done_wb.final_mux    = ex_final_mux;
    done_wb.out_port     = ex_out_port;
    done_wb.next_memaddr = ex_next_memaddr;
    done_wb.u_type       = ex_u_type;
    done_wb.wsel         = ex_wsel;
    done_wb.regwen       = ex_regwen;
    done_wb.temp_halt    = ex_halt;
    if (mem_op && rd_req) begin
      done_wb.dmemload = dmemload_in;
    end
`ifdef ATOMIC_LLSC_EN
    else if (ex_sc) begin
      done_wb.dmemload = sc_fail ? 32'd0 : 32'd1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      wb_q  <= '0;
    end else begin
      case (state)
        HALTED: begin
          wb_q.regwen <= 1'b0;
        end
        default: begin
          if (complete) begin
            wb_q  <= done_wb;
            state <= ex_halt ? HALTED : IDLE;
          end else begin
            wb_q.regwen    <= 1'b0;
            wb_q.temp_halt <= 1'b0;
            state          <= mem_op ? BUSY : IDLE;
          end
        end
      endcase
    end
  end

  assign wb_final_mux    = wb_q.final_mux;
  assign wb_dmemload     = wb_q.dmemload;
  assign wb_out_port     = wb_q.out_port;
  assign wb_next_memaddr = wb_q.next_memaddr;
  assign wb_u_type       = wb_q.u_type;
  assign wb_wsel         = wb_q.wsel;
  assign wb_regwen       = wb_q.regwen;
  assign wb_temp_halt    = wb_q.temp_halt;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_valid, ex_dren, ex_dwen, ex_regwen, ex_halt, dhit;
  logic [31:0] ex_addr, ex_store, ex_out_port, ex_next_memaddr, ex_u_type, dmemload_in;
  logic [2:0]  ex_final_mux;
  logic [4:0]  ex_wsel;
  logic        dmemREN, dmemWEN, mem_stall, wb_regwen, wb_temp_halt;
  logic [31:0] dmemaddr, dmemstore, wb_dmemload, wb_out_port, wb_next_memaddr, wb_u_type;
  logic [2:0]  wb_final_mux;
  logic [4:0]  wb_wsel;
`ifdef ATOMIC_LLSC_EN
  logic        ex_ll, ex_sc, snoop_inv;
  logic [31:0] snoop_addr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  memory_stage dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
    .ex_addr(ex_addr), .ex_store(ex_store), .ex_final_mux(ex_final_mux),
    .ex_out_port(ex_out_port), .ex_next_memaddr(ex_next_memaddr), .ex_u_type(ex_u_type),
    .ex_wsel(ex_wsel), .ex_regwen(ex_regwen), .ex_halt(ex_halt),
`ifdef ATOMIC_LLSC_EN
    .ex_ll(ex_ll), .ex_sc(ex_sc), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
`endif
    .dhit(dhit), .dmemload_in(dmemload_in), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .wb_final_mux(wb_final_mux), .wb_dmemload(wb_dmemload), .wb_out_port(wb_out_port),
    .wb_next_memaddr(wb_next_memaddr), .wb_u_type(wb_u_type), .wb_wsel(wb_wsel),
    .wb_regwen(wb_regwen), .wb_temp_halt(wb_temp_halt)
  );

  typedef struct {
    logic        valid, dren, dwen, dhit, regwen;
    logic [31:0] din, ut, addr;
    logic [4:0]  wsel;
    logic        e_ren, e_wen, e_stall, e_regwen;
    logic [31:0] e_ut, e_dml;
    logic [4:0]  e_wsel;
  } vec_t;

  typedef struct {
    logic        regwen;
    logic [31:0] ut, dml;
    logic [4:0]  wsel;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_dren = 0; ex_dwen = 0; ex_regwen = 0; ex_halt = 0; dhit = 0;
    ex_addr = 0; ex_store = 0; ex_out_port = 0; ex_next_memaddr = 0; ex_u_type = 0;
    dmemload_in = 0; ex_final_mux = 0; ex_wsel = 0;
`ifdef ATOMIC_LLSC_EN
    ex_ll = 0; ex_sc = 0; snoop_inv = 0; snoop_addr = 0;
`endif
  endtask

  initial begin
    int ren_cnt, stall_cnt;
    exp_t e;
    //         valid dren dwen dhit regw din            ut             addr          wsel  ren wen stl regw e_ut           e_dml          e_wsel
    vecs[0] = '{1, 0, 0, 0, 1, 32'h0,          32'h1234_0000, 32'h0,        5'd5,  0, 0, 0, 1, 32'h1234_0000, 32'h0,          5'd5};
    vecs[1] = '{1, 1, 0, 1, 1, 32'hCAFE_0001,  32'h0000_000A, 32'h0000_0040, 5'd7,  1, 0, 0, 1, 32'h0000_000A, 32'hCAFE_0001, 5'd7};
    vecs[2] = '{1, 0, 1, 1, 0, 32'h1111_1111,  32'h0000_000B, 32'h0000_0044, 5'd3,  0, 1, 0, 0, 32'h0000_000B, 32'hCAFE_0001, 5'd3};
    vecs[3] = '{0, 1, 0, 0, 1, 32'h0,          32'h0000_000C, 32'h0000_0048, 5'd9,  0, 0, 0, 0, 32'h0000_000B, 32'hCAFE_0001, 5'd3};
    vecs[4] = '{1, 0, 0, 1, 1, 32'h0BAD_0BAD,  32'h0000_000D, 32'h0,        5'd10, 0, 0, 0, 1, 32'h0000_000D, 32'hCAFE_0001, 5'd10};
    vecs[5] = '{1, 1, 1, 1, 1, 32'h5555_AAAA,  32'h0000_000E, 32'h0000_004C, 5'd31, 1, 0, 0, 1, 32'h0000_000E, 32'h5555_AAAA, 5'd31};

    idle_inputs();
    nRST = 0;
    #12;
    chk("rst_wb_regwen", wb_regwen, 0);
    chk("rst_wb_u_type", wb_u_type, 0);
    chk("rst_wb_dmemload", wb_dmemload, 0);
    chk("rst_wb_temp_halt", wb_temp_halt, 0);
    chk("rst_mem_stall", mem_stall, 0);
    @(negedge CLK); nRST = 1;

    // Single-cycle vectors: strobes checked before the edge, wb_* via scoreboard after.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      idle_inputs();
      ex_valid = vecs[i].valid; ex_dren = vecs[i].dren; ex_dwen = vecs[i].dwen;
      dhit = vecs[i].dhit; ex_regwen = vecs[i].regwen; dmemload_in = vecs[i].din;
      ex_u_type = vecs[i].ut; ex_addr = vecs[i].addr; ex_wsel = vecs[i].wsel;
      ex_final_mux = 3'd3;
      #1;
      chk($sformatf("v%0d_ren", i), dmemREN, vecs[i].e_ren);
      chk($sformatf("v%0d_wen", i), dmemWEN, vecs[i].e_wen);
      chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].e_stall);
      chk($sformatf("v%0d_addr", i), dmemaddr, vecs[i].addr);
      sb.push_back('{vecs[i].e_regwen, vecs[i].e_ut, vecs[i].e_dml, vecs[i].e_wsel});
      @(posedge CLK); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_wb_regwen", i), wb_regwen, e.regwen);
      chk($sformatf("v%0d_wb_u_type", i), wb_u_type, e.ut);
      chk($sformatf("v%0d_wb_dmemload", i), wb_dmemload, e.dml);
      chk($sformatf("v%0d_wb_wsel", i), wb_wsel, e.wsel);
    end
    chk("wb_final_mux", wb_final_mux, 3);

    // Load with dhit low for three cycles.
    ren_cnt = 0; stall_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      idle_inputs();
      ex_valid = 1; ex_dren = 1; ex_addr = 32'h40; ex_regwen = 1; ex_wsel = 5'd4;
      dhit = (k == 3); dmemload_in = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      ren_cnt += dmemREN; stall_cnt += mem_stall;
      @(posedge CLK); #1;
      if (k < 3) chk($sformatf("stall%0d_wb_regwen", k), wb_regwen, 0);
    end
    chk("ld_ren_cycles", ren_cnt, 4);
    chk("ld_stall_cycles", stall_cnt, 3);
    chk("ld_wb_dmemload", wb_dmemload, 32'hDEAD_BEEF);
    chk("ld_wb_regwen", wb_regwen, 1);

    // Halt after a load, then a load that must be ignored.
    @(negedge CLK); idle_inputs();
    ex_valid = 1; ex_dren = 1; dhit = 1; dmemload_in = 32'h77;
    @(negedge CLK); idle_inputs();
    ex_valid = 1; ex_halt = 1;
    @(posedge CLK); #1;
    chk("halt_temp_halt", wb_temp_halt, 1);
    chk("halt_ld_data", wb_dmemload, 32'h77);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); idle_inputs();
      ex_valid = 1; ex_dren = 1; ex_regwen = 1;
      #1;
      chk("halted_ren", dmemREN, 0);
      chk("halted_stall", mem_stall, 0);
      @(posedge CLK); #1;
      chk("halted_temp_halt", wb_temp_halt, 1);
      chk("halted_regwen", wb_regwen, 0);
    end

    // Reset out of HALTED, then reset mid-request.
    @(negedge CLK); idle_inputs(); nRST = 0;
    @(negedge CLK); nRST = 1;
    ex_valid = 1; ex_regwen = 1; ex_u_type = 32'h00AB_0000;
    @(negedge CLK); idle_inputs();
    ex_valid = 1; ex_dren = 1; ex_addr = 32'h60;
    @(posedge CLK); #2;
    chk("busy_ren", dmemREN, 1);
    nRST = 0; #1;
    chk("rst_busy_ren", dmemREN, 0);
    chk("rst_busy_wen", dmemWEN, 0);
    chk("rst_busy_u_type", wb_u_type, 0);
    chk("rst_busy_regwen", wb_regwen, 0);
    @(negedge CLK); nRST = 1; dhit = 1; dmemload_in = 32'h1357_9BDF;
    #1;
    chk("post_rst_ren", dmemREN, 1);
    chk("post_rst_stall", mem_stall, 0);
    @(posedge CLK); #1;
    chk("post_rst_dml", wb_dmemload, 32'h1357_9BDF);

`ifdef ATOMIC_LLSC_EN
    // LL then SC succeeds.
    @(negedge CLK); idle_inputs();
    ex_valid = 1; ex_dren = 1; ex_ll = 1; ex_addr = 32'h80; dhit = 1; dmemload_in = 32'h5;
    @(negedge CLK); idle_inputs();
    ex_valid = 1; ex_dwen = 1; ex_sc = 1; ex_addr = 32'h80; dhit = 1;
    #1;
    chk("sc_ok_wen", dmemWEN, 1);
    @(posedge CLK); #1;
    chk("sc_ok_dml", wb_dmemload, 1);
    // LL, snoop invalidation, SC fails.
    @(negedge CLK); idle_inputs();
    ex_valid = 1; ex_dren = 1; ex_ll = 1; ex_addr = 32'h80; dhit = 1; dmemload_in = 32'h5;
    @(negedge CLK); idle_inputs();
    snoop_inv = 1; snoop_addr = 32'h80;
    @(negedge CLK); idle_inputs();
    ex_valid = 1; ex_dwen = 1; ex_sc = 1; ex_addr = 32'h80; dhit = 0;
    #1;
    chk("sc_fail_wen", dmemWEN, 0);
    chk("sc_fail_stall", mem_stall, 0);
    @(posedge CLK); #1;
    chk("sc_fail_dml", wb_dmemload, 0);
`endif

    @(negedge CLK); idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory pipeline stage of the multicore MIPS-style core. Sits between the EX/MEM latch and the writeback stage.
- Issues data-cache read/write requests and stalls upstream until the cache reports dhit.
- Registers the MEM/WB payload (final_mux, dmemload, out_port, next_memaddr, u_type, temp_halt, wsel, regwen) that writeback consumes.
- One outstanding request at a time. Halt is sticky.

Parameters:
- WORD_W, 32, datapath word width (matches cpu_types_pkg word_t)
- REG_W, 5, register-file address width

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM holds a live instruction
- ex_dren / ex_dwen  in  1 / 1  load / store op
- ex_addr  in  WORD_W  effective address
- ex_store  in  WORD_W  store data
- ex_final_mux  in  3  writeback source select
- ex_out_port, ex_next_memaddr, ex_u_type  in  WORD_W each  writeback candidates
- ex_wsel  in  REG_W  destination register
- ex_regwen  in  1  register write enable
- ex_halt  in  1  halt instruction
- dhit  in  1  cache access complete this cycle
- dmemload_in  in  WORD_W  cache read data, valid with dhit
- dmemREN / dmemWEN  out  1 / 1  cache request strobes
- dmemaddr, dmemstore  out  WORD_W each  cache address / store data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wb_final_mux  out  3
- wb_dmemload, wb_out_port, wb_next_memaddr, wb_u_type  out  WORD_W each
- wb_wsel  out  REG_W
- wb_regwen  out  1
- wb_temp_halt  out  1

Behaviour:
- Reset (async, nRST=0): state=IDLE; all wb_* outputs 0. Reset mid-request drops dmemREN/dmemWEN immediately; the request is abandoned.
- FSM states:
  - IDLE: no outstanding access.
  - BUSY: request issued, dhit not yet seen.
  - HALTED: terminal until reset.
- mem_op = ex_valid & (ex_dren | ex_dwen) & state!=HALTED.
- Request strobes are combinational: dmemREN=mem_op&ex_dren and dmemWEN=mem_op&ex_dwen in IDLE and BUSY. dmemaddr=ex_addr; dmemstore=ex_store. ex_dren&ex_dwen together is illegal; read takes priority.
- mem_stall = mem_op & ~dhit.
- IDLE transitions:
  - mem_op & ~dhit -> BUSY.
  - mem_op & dhit (same-cycle hit) -> completes, stays IDLE.
  - Non-memory valid op -> completes in 1 cycle.
- BUSY: dhit -> IDLE, op completes; else hold. EX/MEM inputs must remain stable while stalled (guaranteed by mem_stall).
- Completion edge:
  - wb_* <= ex_* payload.
  - wb_dmemload <= dmemload_in on a load; unchanged otherwise.
  - wb_temp_halt <= ex_halt.
- Stalled cycle edge: bubble. wb_regwen<=0, wb_temp_halt<=0, other wb_* hold.
- ex_valid=0: bubble on wb_*.
- Valid ex_halt completion: wb_temp_halt=1 and next state HALTED. In HALTED, no requests, mem_stall=0, wb_temp_halt stays 1, wb_regwen=0.
- dhit while no request is outstanding: ignored.
- Latency: non-memory op 1 cycle; memory op 1 + (cycles until dhit).

Optional Feature:
- Macro: ATOMIC_LLSC_EN.
- With the macro, the block adds these ports:
  - ex_ll, ex_sc  in  1 each
  - snoop_inv  in  1
  - snoop_addr  in  WORD_W
- With the macro, the block keeps a link register {link_valid, link_addr}, reset to 0:
  - LL is a load; on completion, link_valid<=1 and link_addr<=ex_addr.
  - SC with link_valid & link_addr==ex_addr issues a write. On dhit, wb_dmemload<=1 and link_valid<=0.
  - SC failure issues no write and completes in 1 cycle with wb_dmemload<=0.
  - snoop_inv & snoop_addr==link_addr clears link_valid. This also applies the same cycle as an SC check, and the SC then fails.
  - A completing store to link_addr from this core clears link_valid.
- Without the macro: the added ports do not exist and there is no link state.

Decomposition:
- cpu_types_pkg receives:
  - mem_state_t enum {IDLE, BUSY, HALTED}
  - word_t, regbits_t (existing)
  - mem_wb_t packed struct bundling the wb_* payload, so a bubble is one assignment
- Sub-module llsc_link_reg holds link state, match and invalidation logic. Instantiated only under ATOMIC_LLSC_EN.

Test Plan:
- Non-memory op (ex_regwen=1, ex_u_type=32'h1234_0000, final_mux=3) -> wb_u_type=32'h1234_0000 and wb_regwen=1 one edge later; mem_stall never asserts.
- Load to 32'h0000_0040 with dhit held low 3 cycles, then dmemload_in=32'hDEAD_BEEF -> dmemREN high 4 cycles, mem_stall high 3, wb_regwen=0 during the stall, then wb_dmemload=32'hDEAD_BEEF.
- Store with same-cycle dhit -> dmemWEN for 1 cycle, no stall, FSM stays IDLE.
- Halt following a load -> wb_temp_halt=1 and held; a subsequent ex_dren issues no dmemREN.
- nRST asserted while in BUSY -> strobes drop immediately, all wb_*=0, state IDLE after release.
- ATOMIC_LLSC_EN: LL 0x80 then SC 0x80 -> wb_dmemload=1. Repeat with snoop_inv at 0x80 between them -> wb_dmemload=0 and no dmemWEN.
